// File: rtl/register_file_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
package register_file_mp_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 4;

  // Register indices used by the controller
  localparam int R0 = 0;
  localparam int R1 = 1;
  localparam int R2 = 2;
  localparam int R3 = 3;

  // An address is usable when it names an existing register and is not the
  // hardwired zero register.
  function automatic logic addr_valid(input int unsigned addr,
                                      input int unsigned num_regs,
                                      input bit          zero_reg0);
    return (addr < num_regs) && !(zero_reg0 && (addr == 0));
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between the controller/ALU side and the register file.
interface register_file_mp_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int NUM_REGS = 4
) ();

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                rsv_en;
  logic [ADDR_W-1:0]   rsv_addr;
  logic [ADDR_W-1:0]   rd_a_addr;
  logic [DATA_W-1:0]   rd_a_data;
  logic                rd_a_busy;
  logic [ADDR_W-1:0]   rd_b_addr;
  logic [DATA_W-1:0]   rd_b_data;
  logic                rd_b_busy;
  logic [NUM_REGS-1:0] busy_vec;
  logic [7:0]          wr_count;

  modport master (
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_a_addr, rd_b_addr,
    input  rd_a_data, rd_a_busy, rd_b_data, rd_b_busy, busy_vec, wr_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_a_addr, rd_b_addr,
    output rd_a_data, rd_a_busy, rd_b_data, rd_b_busy, busy_vec, wr_count
  );

endinterface

// File: rtl/register_file_mp_read_port.sv
// One combinational read port: validity check, write bypass, storage mux.
module regfile_read_port
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = 2,
  parameter int ZERO_REG0 = 0
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                bypass_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W-1:0]   regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy_q,
  output logic [DATA_W-1:0]   data,
  output logic                busy
);

  logic valid;
  assign valid = addr_valid(32'(addr), NUM_REGS, ZERO_REG0 != 0);

  // Invalid address reads zero; a same-cycle write wins over storage and is
  // never busy because the write itself releases the register.
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (valid) begin
      if (bypass_en && (wr_addr == addr)) begin
        data = wr_data;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr == ADDR_W'(i)) begin
            data = regs[i];
            busy = busy_q[i];
          end
        end
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// NUM_REGS x DATA_W register file: one write port, two read ports with
// write bypass, per-register busy scoreboard and a saturating write counter.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int              DATA_W    = DEF_DATA_W,
  parameter int              NUM_REGS  = DEF_NUM_REGS,
  parameter int              ADDR_W    = 2,
  parameter int              ZERO_REG0 = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  register_file_mp_if.slave bus
);

  logic [DATA_W-1:0]   storage [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [7:0]          wr_count_q;
  logic                wr_fire;
  logic                rsv_fire;
  logic                bypass_en;

  assign wr_fire  = bus.wr_en  && addr_valid(32'(bus.wr_addr),  NUM_REGS, ZERO_REG0 != 0);
  assign rsv_fire = bus.rsv_en && addr_valid(32'(bus.rsv_addr), NUM_REGS, ZERO_REG0 != 0);

  // While reset is held reads must show the reset image, not a pending write.
  assign bypass_en = bus.wr_en && !rst;

  // Register storage: write lands on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) storage[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_fire && (bus.wr_addr == ADDR_W'(i))) storage[i] <= bus.wr_data;
      end
    end
  end

  // Busy scoreboard: write releases, reserve sets; reserve wins on a tie
  // because it marks the next producer. Bit 0 can never be set when register
  // 0 is hardwired, since reserves to it are invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rsv_fire && (bus.rsv_addr == ADDR_W'(i)))     busy_q[i] <= 1'b1;
        else if (wr_fire && (bus.wr_addr == ADDR_W'(i))) busy_q[i] <= 1'b0;
      end
    end
  end

  // Accepted-write counter, sticks at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  wr_count_q <= '0;
    else if (wr_fire && (wr_count_q != 8'hFF)) wr_count_q <= wr_count_q + 8'd1;
  end

  assign bus.busy_vec = busy_q;
  assign bus.wr_count = wr_count_q;

  regfile_read_port #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .ZERO_REG0(ZERO_REG0)
  ) u_rd_a (
    .addr(bus.rd_a_addr), .bypass_en(bypass_en), .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data), .regs(storage), .busy_q(busy_q),
    .data(bus.rd_a_data), .busy(bus.rd_a_busy)
  );

  regfile_read_port #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .ZERO_REG0(ZERO_REG0)
  ) u_rd_b (
    .addr(bus.rd_b_addr), .bypass_en(bypass_en), .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data), .regs(storage), .busy_q(busy_q),
    .data(bus.rd_b_data), .busy(bus.rd_b_busy)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: default 4-register file plus a 3-register, zero-r0 variant.
module tb_register_file_mp;
  import register_file_mp_pkg::*;

  logic clk;
  logic rst;

  register_file_mp_if #(.DATA_W(8), .ADDR_W(2), .NUM_REGS(4)) a_if ();
  register_file_mp_if #(.DATA_W(8), .ADDR_W(2), .NUM_REGS(3)) z_if ();

  register_file_mp #(
    .DATA_W(8), .NUM_REGS(4), .ADDR_W(2), .ZERO_REG0(0), .RESET_VAL(8'h00)
  ) u_dut (.clk(clk), .rst(rst), .bus(a_if.slave));

  register_file_mp #(
    .DATA_W(8), .NUM_REGS(3), .ADDR_W(2), .ZERO_REG0(1), .RESET_VAL(8'h00)
  ) u_dut_z (.clk(clk), .rst(rst), .bus(z_if.slave));

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_if.wr_en = 0; a_if.wr_addr = 0; a_if.wr_data = 0;
    a_if.rsv_en = 0; a_if.rsv_addr = 0; a_if.rd_a_addr = 0; a_if.rd_b_addr = 0;
    z_if.wr_en = 0; z_if.wr_addr = 0; z_if.wr_data = 0;
    z_if.rsv_en = 0; z_if.rsv_addr = 0; z_if.rd_a_addr = 0; z_if.rd_b_addr = 0;
    tick();
    tick();

    // Reset image on every address, both ports
    for (int i = 0; i < 4; i++) begin
      a_if.rd_a_addr = 2'(i);
      a_if.rd_b_addr = 2'(3 - i);
      #1;
      check_val("rst_rd_a_data", 32'(a_if.rd_a_data), 32'h00);
      check_val("rst_rd_a_busy", 32'(a_if.rd_a_busy), 32'h0);
      check_val("rst_rd_b_data", 32'(a_if.rd_b_data), 32'h00);
      check_val("rst_rd_b_busy", 32'(a_if.rd_b_busy), 32'h0);
    end
    rst = 1'b0;
    #1;
    check_val("rst_busy_vec", 32'(a_if.busy_vec), 32'h0);
    check_val("rst_wr_count", 32'(a_if.wr_count), 32'h0);
    tick();

    // Write r2 = A5: bypass then storage
    a_if.wr_en = 1; a_if.wr_addr = 2'(R2); a_if.wr_data = 8'hA5; a_if.rd_a_addr = 2'(R2);
    #1;
    check_val("byp_r2_data", 32'(a_if.rd_a_data), 32'hA5);
    tick();
    a_if.wr_en = 0;
    #1;
    check_val("sto_r2_data", 32'(a_if.rd_a_data), 32'hA5);
    check_val("wr_count_1", 32'(a_if.wr_count), 32'h1);

    // Reserve r1, then release it by writing 3C
    a_if.rsv_en = 1; a_if.rsv_addr = 2'(R1); a_if.rd_b_addr = 2'(R1);
    #1;
    check_val("rsv_same_cyc_busy", 32'(a_if.rd_b_busy), 32'h0);
    tick();
    a_if.rsv_en = 0;
    #1;
    check_val("rsv_r1_busy", 32'(a_if.rd_b_busy), 32'h1);
    check_val("rsv_busy_vec", 32'(a_if.busy_vec), 32'h2);
    a_if.wr_en = 1; a_if.wr_addr = 2'(R1); a_if.wr_data = 8'h3C;
    #1;
    check_val("rel_byp_busy", 32'(a_if.rd_b_busy), 32'h0);
    check_val("rel_byp_data", 32'(a_if.rd_b_data), 32'h3C);
    check_val("rel_busy_vec_pre", 32'(a_if.busy_vec), 32'h2);
    tick();
    a_if.wr_en = 0;
    #1;
    check_val("rel_busy_vec", 32'(a_if.busy_vec), 32'h0);
    check_val("rel_r1_data", 32'(a_if.rd_b_data), 32'h3C);
    check_val("wr_count_2", 32'(a_if.wr_count), 32'h2);

    // Same-edge write and reserve to r3: data written, busy stays set
    a_if.wr_en = 1; a_if.wr_addr = 2'(R3); a_if.wr_data = 8'h77;
    a_if.rsv_en = 1; a_if.rsv_addr = 2'(R3);
    tick();
    a_if.wr_en = 0; a_if.rsv_en = 0; a_if.rd_a_addr = 2'(R3);
    #1;
    check_val("wr_rsv_r3_data", 32'(a_if.rd_a_data), 32'h77);
    check_val("wr_rsv_r3_busy", 32'(a_if.rd_a_busy), 32'h1);
    check_val("wr_rsv_busy_vec", 32'(a_if.busy_vec), 32'h8);
    check_val("wr_count_3", 32'(a_if.wr_count), 32'h3);

    // Zero-r0 / 3-register variant
    z_if.wr_en = 1; z_if.wr_addr = 2'd0; z_if.wr_data = 8'hFF;
    z_if.rsv_en = 1; z_if.rsv_addr = 2'd0; z_if.rd_a_addr = 2'd0;
    #1;
    check_val("z_r0_nobyp", 32'(z_if.rd_a_data), 32'h00);
    tick();
    z_if.wr_en = 0; z_if.rsv_en = 0;
    #1;
    check_val("z_r0_data", 32'(z_if.rd_a_data), 32'h00);
    check_val("z_r0_busy", 32'(z_if.rd_a_busy), 32'h0);
    check_val("z_busy_vec", 32'(z_if.busy_vec), 32'h0);
    check_val("z_wr_count_0", 32'(z_if.wr_count), 32'h0);
    z_if.wr_en = 1; z_if.wr_addr = 2'd3; z_if.wr_data = 8'h5A; z_if.rd_b_addr = 2'd3;
    #1;
    check_val("z_a3_nobyp", 32'(z_if.rd_b_data), 32'h00);
    tick();
    z_if.wr_en = 0;
    #1;
    check_val("z_a3_data", 32'(z_if.rd_b_data), 32'h00);
    check_val("z_a3_count", 32'(z_if.wr_count), 32'h0);
    z_if.wr_en = 1; z_if.wr_addr = 2'd2; z_if.wr_data = 8'h12;
    z_if.rsv_en = 1; z_if.rsv_addr = 2'd1; z_if.rd_a_addr = 2'd2; z_if.rd_b_addr = 2'd1;
    tick();
    z_if.wr_en = 0; z_if.rsv_en = 0;
    #1;
    check_val("z_r2_data", 32'(z_if.rd_a_data), 32'h12);
    check_val("z_r1_busy", 32'(z_if.rd_b_busy), 32'h1);
    check_val("z_busy_vec_r1", 32'(z_if.busy_vec), 32'h2);
    check_val("z_wr_count_1", 32'(z_if.wr_count), 32'h1);

    // Fill r0..r3 = 11..44, reserve r2 alongside the r3 write
    for (int i = 0; i < 4; i++) begin
      a_if.wr_en = 1; a_if.wr_addr = 2'(i); a_if.wr_data = 8'(8'h11 * (i + 1));
      a_if.rsv_en = (i == 3); a_if.rsv_addr = 2'(R2);
      tick();
    end
    a_if.wr_en = 0; a_if.rsv_en = 0;
    a_if.rd_a_addr = 2'(R0); a_if.rd_b_addr = 2'(R3);
    #1;
    check_val("fill_r0", 32'(a_if.rd_a_data), 32'h11);
    check_val("fill_r3", 32'(a_if.rd_b_data), 32'h44);
    check_val("fill_busy_vec", 32'(a_if.busy_vec), 32'h4);
    check_val("fill_wr_count", 32'(a_if.wr_count), 32'h7);

    // Mid-cycle async reset with a write pending: no clock edge needed
    #2;
    a_if.wr_en = 1; a_if.wr_addr = 2'(R0); a_if.wr_data = 8'h99;
    rst = 1'b1;
    #1;
    check_val("arst_rd_a", 32'(a_if.rd_a_data), 32'h00);
    check_val("arst_rd_b", 32'(a_if.rd_b_data), 32'h00);
    check_val("arst_busy_vec", 32'(a_if.busy_vec), 32'h0);
    check_val("arst_wr_count", 32'(a_if.wr_count), 32'h0);
    a_if.rd_a_addr = 2'(R2);
    #1;
    check_val("arst_r2_busy", 32'(a_if.rd_a_busy), 32'h0);
    a_if.wr_en = 0;
    tick();
    rst = 1'b0;
    tick();

    // 300 back-to-back writes, reads of other addresses against a model
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    for (int k = 0; k < 300; k++) begin
      a_if.wr_en = 1;
      a_if.wr_addr = 2'(k % 4);
      a_if.wr_data = 8'(k) ^ 8'h5A;
      a_if.rd_a_addr = 2'((k + 1) % 4);
      a_if.rd_b_addr = 2'((k + 2) % 4);
      #1;
      check_val("burst_rd_a", 32'(a_if.rd_a_data), 32'(model[(k + 1) % 4]));
      check_val("burst_rd_b", 32'(a_if.rd_b_data), 32'(model[(k + 2) % 4]));
      if (k == 254) check_val("burst_count_254", 32'(a_if.wr_count), 32'd254);
      tick();
      model[k % 4] = 8'(k) ^ 8'h5A;
    end
    a_if.wr_en = 0;
    #1;
    check_val("burst_wr_count_sat", 32'(a_if.wr_count), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
